dest_fifo_stage: RTL and testbench

//  Destination stage downstream of the VC0/VC1 arbitration mux. Accepts one 6-bit word per cycle,

---
 rtl/dest_fifo_stage.sv | 129 ++++++++++++
 tb/tb_dest_fifo_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dest_fifo_stage.sv
// Destination stage: steers each incoming word into FIFO D0 or D1 by its destination bit and raises pause/overflow flags.
// Optional per-FIFO pop counters (cnt_D0/cnt_D1) are enabled by defining DEST_CNT_EN.
module dest_fifo_stage #(
    parameter int DATA_W   = 6,
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 2,
    parameter int DEST_BIT = 4,
    parameter int AF_TH    = 3
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop_D0,
    input  logic              pop_D1,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic              empty_D0,
    output logic              empty_D1,
    output logic              pausa_out,
    output logic              error_out
`ifdef DEST_CNT_EN
    ,
    output logic [7:0]        cnt_D0,
    output logic [7:0]        cnt_D1
`endif
);

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_AF_TH = (ADDR_W+1)'(AF_TH);

    logic [DATA_W-1:0] r_mem    [2][DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr [2];
    logic [ADDR_W-1:0] r_rd_ptr [2];
    logic [ADDR_W:0]   r_occ    [2];
    logic [DATA_W-1:0] r_dout   [2];
    logic [1:0]        r_vout;
    logic              r_err;

    logic [1:0]        w_push;
    logic [1:0]        w_pop;
    logic [1:0]        w_full;
    logic [1:0]        w_wr_en;
    logic              w_ovf;

    always_comb begin
        w_push[0] = valid_in & ~data_in[DEST_BIT];
        w_push[1] = valid_in &  data_in[DEST_BIT];
        w_pop[0]  = pop_D0 & (r_occ[0] != '0);
        w_pop[1]  = pop_D1 & (r_occ[1] != '0);
        w_full[0] = (r_occ[0] == C_DEPTH);
        w_full[1] = (r_occ[1] == C_DEPTH);
        // A pop on a full FIFO frees the slot the simultaneous push lands in
        w_wr_en   = w_push & (~w_full | w_pop);
        w_ovf     = |(w_push & w_full & ~w_pop);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_wr_en[i]) begin
                r_mem[i][r_wr_ptr[i]] <= data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 2; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_occ[i]    <= '0;
                r_dout[i]   <= '0;
            end
            r_vout <= '0;
            r_err  <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_wr_en[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + ADDR_W'(1);
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + ADDR_W'(1);
                    r_dout[i]   <= r_mem[i][r_rd_ptr[i]];
                end
                case ({w_wr_en[i], w_pop[i]})
                    2'b10:   r_occ[i] <= r_occ[i] + (ADDR_W+1)'(1);
                    2'b01:   r_occ[i] <= r_occ[i] - (ADDR_W+1)'(1);
                    default: r_occ[i] <= r_occ[i];
                endcase
            end
            r_vout <= w_pop;
            if (w_ovf) begin
                r_err <= 1'b1;
            end
        end
    end

    assign data_out0  = r_dout[0];
    assign data_out1  = r_dout[1];
    assign valid_out0 = r_vout[0];
    assign valid_out1 = r_vout[1];
    assign empty_D0   = (r_occ[0] == '0);
    assign empty_D1   = (r_occ[1] == '0);
    assign pausa_out  = (r_occ[0] >= C_AF_TH) | (r_occ[1] >= C_AF_TH);
    assign error_out  = r_err;

`ifdef DEST_CNT_EN
    logic [7:0] r_cnt [2];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_vout[i] && (r_cnt[i] != 8'hFF)) begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign cnt_D0 = r_cnt[0];
    assign cnt_D1 = r_cnt[1];
`endif

endmodule

// File: tb/tb_dest_fifo_stage.sv
// Self-checking bench for dest_fifo_stage: directed scenarios plus a randomized run against a queue-based model.
// Pop-counter checks are compiled in only when DEST_CNT_EN is defined.
module tb_dest_fifo_stage;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       valid_in = 1'b0;
    logic [5:0] data_in = '0;
    logic       pop_D0 = 1'b0;
    logic       pop_D1 = 1'b0;
    logic [5:0] data_out0, data_out1;
    logic       valid_out0, valid_out1, empty_D0, empty_D1, pausa_out, error_out;
`ifdef DEST_CNT_EN
    logic [7:0] cnt_D0, cnt_D1;
`endif

    dest_fifo_stage dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .pop_D0     (pop_D0),
        .pop_D1     (pop_D1),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .empty_D0   (empty_D0),
        .empty_D1   (empty_D1),
        .pausa_out  (pausa_out),
`ifdef DEST_CNT_EN
        .cnt_D0     (cnt_D0),
        .cnt_D1     (cnt_D1),
`endif
        .error_out  (error_out)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per destination, plus last-read registers and sticky error
    logic [5:0] q0[$];
    logic [5:0] q1[$];
    logic [5:0] m_dout [2];
    logic       m_vout [2];
    logic       m_err;
    int         m_cnt  [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] dut_vec;
    assign dut_vec = {data_out1, valid_out1, data_out0, valid_out0, empty_D1, empty_D0, pausa_out, error_out};

    localparam logic [17:0] RESET_VEC = 18'b000000_0_000000_0_1_1_0_0;

    function automatic logic [17:0] exp_vec();
        logic pause;
        pause = (q0.size() >= 3) || (q1.size() >= 3);
        return {m_dout[1], m_vout[1], m_dout[0], m_vout[0],
                q1.size() == 0, q0.size() == 0, pause, m_err};
    endfunction

    task automatic model_clear();
        q0.delete();
        q1.delete();
        m_dout[0] = '0; m_dout[1] = '0;
        m_vout[0] = 1'b0; m_vout[1] = 1'b0;
        m_err = 1'b0;
        m_cnt[0] = 0; m_cnt[1] = 0;
    endtask

    // Drive one cycle of stimulus, advance the model, and return #1 after the rising edge
    task automatic step(input logic v, input logic [5:0] d, input logic p0, input logic p1);
        int  pre0, pre1;
        logic popped0, popped1;
        valid_in = v; data_in = d; pop_D0 = p0; pop_D1 = p1;
        for (int i = 0; i < 2; i++)
            if (m_vout[i] && m_cnt[i] < 255) m_cnt[i]++;
        pre0 = q0.size(); pre1 = q1.size();
        popped0 = p0 && pre0 > 0;
        popped1 = p1 && pre1 > 0;
        m_vout[0] = popped0;
        m_vout[1] = popped1;
        if (popped0) m_dout[0] = q0.pop_front();
        if (popped1) m_dout[1] = q1.pop_front();
        if (v) begin
            if (!d[4]) begin
                if (pre0 < 4 || popped0) q0.push_back(d); else m_err = 1'b1;
            end else begin
                if (pre1 < 4 || popped1) q1.push_back(d); else m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        valid_in = 0; data_in = '0; pop_D0 = 0; pop_D1 = 0;
        reset_L = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_state: got %b expected %b", dut_vec, RESET_VEC);
        end
        apply_reset();
        n_checks++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_release: got %b expected %b", dut_vec, RESET_VEC);
        end
    endtask

    task automatic test_basic_steer();
        apply_reset();
        step(1'b1, 6'h12, 1'b0, 1'b0);
        step(1'b1, 6'h05, 1'b0, 1'b0);
        step(1'b0, 6'h00, 1'b1, 1'b1);
        n_checks++;
        if ({data_out1, valid_out1} !== {6'h12, 1'b1}) begin
            n_fail++; $display("FAIL steer_d1: got data=%h valid=%b expected data=12 valid=1", data_out1, valid_out1);
        end
        n_checks++;
        if ({data_out0, valid_out0} !== {6'h05, 1'b1}) begin
            n_fail++; $display("FAIL steer_d0: got data=%h valid=%b expected data=05 valid=1", data_out0, valid_out0);
        end
        step(1'b0, 6'h00, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL steer_idle_hold: got %b expected %b", dut_vec, exp_vec());
        end
    endtask

    task automatic test_fill_overflow();
        logic [5:0] w [5];
        apply_reset();
        for (int k = 0; k < 5; k++) w[k] = 6'($urandom) & 6'h2F;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, w[k], 1'b0, 1'b0);
            n_checks++;
            if (pausa_out !== (k >= 2)) begin
                n_fail++; $display("FAIL fill_pause_%0d: got %b expected %b", k + 1, pausa_out, k >= 2);
            end
            n_checks++;
            if (error_out !== (k == 4)) begin
                n_fail++; $display("FAIL fill_error_%0d: got %b expected %b", k + 1, error_out, k == 4);
            end
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 6'h00, 1'b1, 1'b0);
            n_checks++;
            if ({data_out0, valid_out0, error_out} !== {(k < 4) ? w[k] : w[3], k < 4, 1'b1}) begin
                n_fail++; $display("FAIL drain_%0d: got data=%h valid=%b err=%b expected data=%h valid=%b err=1",
                                   k, data_out0, valid_out0, error_out, (k < 4) ? w[k] : w[3], k < 4);
            end
        end
        n_checks++;
        if (empty_D0 !== 1'b1) begin
            n_fail++; $display("FAIL drain_empty: got %b expected 1", empty_D0);
        end
    endtask

    task automatic test_full_push_pop();
        logic [5:0] w [5];
        apply_reset();
        for (int k = 0; k < 5; k++) w[k] = (6'($urandom) & 6'h2F) | 6'h10;
        for (int k = 0; k < 4; k++) step(1'b1, w[k], 1'b0, 1'b0);
        step(1'b1, w[4], 1'b0, 1'b1);
        n_checks++;
        if ({data_out1, valid_out1, error_out, pausa_out, empty_D1} !== {w[0], 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL full_pushpop: got data=%h v=%b err=%b pause=%b empty=%b expected data=%h v=1 err=0 pause=1 empty=0",
                               data_out1, valid_out1, error_out, pausa_out, empty_D1, w[0]);
        end
        for (int k = 1; k < 5; k++) begin
            step(1'b0, 6'h00, 1'b0, 1'b1);
            n_checks++;
            if ({data_out1, valid_out1} !== {w[k], 1'b1}) begin
                n_fail++; $display("FAIL full_drain_%0d: got data=%h v=%b expected data=%h v=1", k, data_out1, valid_out1, w[k]);
            end
        end
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL full_final: got %b expected %b", dut_vec, exp_vec());
        end
    endtask

    task automatic test_pop_empty();
        apply_reset();
        step(1'b1, 6'h0A, 1'b0, 1'b0);
        step(1'b0, 6'h00, 1'b1, 1'b0);
        step(1'b0, 6'h00, 1'b1, 1'b0);
        n_checks++;
        if ({valid_out0, data_out0, error_out, empty_D0} !== {1'b0, 6'h0A, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL pop_empty: got v=%b data=%h err=%b empty=%b expected v=0 data=0a err=0 empty=1",
                               valid_out0, data_out0, error_out, empty_D0);
        end
        step(1'b1, 6'h03, 1'b1, 1'b0);
        n_checks++;
        if ({valid_out0, empty_D0, error_out} !== 3'b000) begin
            n_fail++; $display("FAIL pushpop_empty: got v=%b empty=%b err=%b expected 0 0 0", valid_out0, empty_D0, error_out);
        end
    endtask

    task automatic test_reset_midburst();
        apply_reset();
        for (int k = 0; k < 6; k++)
            step(1'b1, 6'(k) | ((k % 2) ? 6'h10 : 6'h00), k == 3, k == 4);
        #2;
        reset_L = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++; $display("FAIL midburst_reset: got %b expected %b", dut_vec, RESET_VEC);
        end
        valid_in = 0; pop_D0 = 0; pop_D1 = 0;
        @(negedge clk);
        reset_L = 1'b1;
        step(1'b0, 6'h00, 1'b1, 1'b1);
        n_checks++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++; $display("FAIL midburst_pop_after: got %b expected %b", dut_vec, RESET_VEC);
        end
        step(1'b1, 6'h13, 1'b0, 1'b0);
        step(1'b0, 6'h00, 1'b0, 1'b1);
        n_checks++;
        if ({data_out1, valid_out1, empty_D1} !== {6'h13, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL midburst_fresh: got data=%h v=%b empty=%b expected data=13 v=1 empty=1",
                               data_out1, valid_out1, empty_D1);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if (c == 200) apply_reset();
            step($urandom_range(0, 2) != 0, 6'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random_cycle_%0d: got %b expected %b", c, dut_vec, exp_vec());
            end
`ifdef DEST_CNT_EN
            n_checks++;
            if ({cnt_D1, cnt_D0} !== {8'(m_cnt[1]), 8'(m_cnt[0])}) begin
                n_fail++; $display("FAIL random_cnt_%0d: got %0d/%0d expected %0d/%0d", c, cnt_D0, cnt_D1, m_cnt[0], m_cnt[1]);
            end
`endif
        end
    endtask

`ifdef DEST_CNT_EN
    task automatic test_pop_counter();
        apply_reset();
        step(1'b1, 6'h01, 1'b0, 1'b0);
        for (int k = 0; k < 300; k++) step(1'b1, 6'($urandom) & 6'h2F, 1'b1, 1'b0);
        step(1'b0, 6'h00, 1'b0, 1'b0);
        step(1'b0, 6'h00, 1'b0, 1'b0);
        n_checks++;
        if ({cnt_D0, cnt_D1} !== {8'd255, 8'd0}) begin
            n_fail++; $display("FAIL cnt_saturate: got %0d/%0d expected 255/0", cnt_D0, cnt_D1);
        end
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_basic_steer();
        test_fill_overflow();
        test_full_push_pop();
        test_pop_empty();
        test_reset_midburst();
        test_random();
`ifdef DEST_CNT_EN
        test_pop_counter();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
